// File: rtl/interface_teclado_pkg.sv
// Package shared by the keyboard front end.
// Holds the "no note" code, the arrow auto-repeat FSM state type and a small
// helper used when sizing the shared repeat timer.
package interface_teclado_pkg;

    // botoes_encoded value when no note key is held
    localparam logic [3:0] CODIGO_NENHUMA_NOTA = 4'd0;

    // Arrow auto-repeat FSM states
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,  // waiting for a press
        ESPERA = 2'd1,  // press reported, waiting for the first repeat
        REPETE = 2'd2   // repeating at the repeat period
    } estado_seta_t;

    // Index of each arrow in the two-entry arrow vectors
    localparam int SETA_DIREITA  = 0;
    localparam int SETA_ESQUERDA = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/interface_teclado_debouncer.sv
// Synchroniser + debouncer for one raw key.
// Ports:
//   clock       in  system clock, rising edge
//   reset       in  asynchronous, active-low
//   entrada     in  raw asynchronous key level
//   nivel_novo  out debounced level that takes effect on the next rising edge
//                   (combinational look-ahead of the internal debounced register,
//                   so the parent can register its outputs on the same edge the
//                   debounced level changes)
module interface_teclado_debouncer
    import interface_teclado_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic nivel_novo
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sinc_1;
    logic             sinc_2;
    logic             nivel;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_prox;

    // The counter only runs while the synchronised level disagrees with the
    // debounced one; any agreement clears it, so glitches shorter than the
    // window never get through. It stops at CNT_FIM and so never wraps.
    always_comb begin
        nivel_novo = nivel;
        cnt_prox   = '0;
        if (sinc_2 != nivel) begin
            if (cnt == CNT_FIM) begin
                nivel_novo = sinc_2;
            end else begin
                cnt_prox = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_1 <= 1'b0;
            sinc_2 <= 1'b0;
            nivel  <= 1'b0;
            cnt    <= '0;
        end else begin
            sinc_1 <= entrada;
            sinc_2 <= sinc_1;
            nivel  <= nivel_novo;
            cnt    <= cnt_prox;
        end
    end

endmodule

// File: rtl/interface_teclado.sv
// Keyboard front end: synchronises and debounces the note and menu keys,
// priority-encodes the notes and turns the menu keys into one-cycle pulses,
// with auto-repeat on the arrows.
// Ports:
//   clock, reset (async active-low)
//   teclas_notas [NUM_NOTAS]  raw note keys        tecla_direita/esquerda/enter raw menu keys
//   botoes_encoded [4]        0 = none, k = note k-1 (lowest index wins)
//   nova_nota                 pulse when botoes_encoded takes a new nonzero value
//   right/left_arrow_pressed  press + auto-repeat pulses
//   enter_pressed             press pulse, no repeat
//   estado_direita/esquerda   arrow FSM state (debug)
// Handshake: outputs are plain registered levels/pulses; there is no
// back-pressure, a pulse is high for exactly one clock and must be consumed then.
module interface_teclado
    import interface_teclado_pkg::*;
#(
    parameter int NUM_NOTAS       = 12,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_NOTAS-1:0] teclas_notas,
    input  logic                 tecla_direita,
    input  logic                 tecla_esquerda,
    input  logic                 tecla_enter,
    output logic [3:0]           botoes_encoded,
    output logic                 nova_nota,
    output logic                 right_arrow_pressed,
    output logic                 left_arrow_pressed,
    output logic                 enter_pressed,
    output estado_seta_t         estado_direita,
    output estado_seta_t         estado_esquerda
);

    localparam int NUM_ENTRADAS = NUM_NOTAS + 3;
    localparam int TIMER_MAX    = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int TIMER_W      = (TIMER_MAX < 1) ? 1 : $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] CARGA_ATRASO  = TIMER_W'(REPEAT_DELAY);
    localparam logic [TIMER_W-1:0] CARGA_PERIODO = TIMER_W'(REPEAT_PERIOD);

    logic [NUM_ENTRADAS-1:0] entradas;
    logic [NUM_ENTRADAS-1:0] niveis;

    assign entradas = {tecla_enter, tecla_esquerda, tecla_direita, teclas_notas};

    for (genvar i = 0; i < NUM_ENTRADAS; i++) begin : g_debounce
        interface_teclado_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock      (clock),
            .reset      (reset),
            .entrada    (entradas[i]),
            .nivel_novo (niveis[i])
        );
    end

    // Debounced levels as they will be after the current edge
    logic [NUM_NOTAS-1:0] notas;
    logic [1:0]           setas;
    logic                 enter_nivel;

    assign notas       = niveis[NUM_NOTAS-1:0];
    assign setas       = niveis[NUM_NOTAS+1:NUM_NOTAS];
    assign enter_nivel = niveis[NUM_NOTAS+2];

    // ---------------- note encoder ----------------
    logic [3:0] cod_prox;
    logic       nova_prox;

    always_comb begin
        cod_prox = CODIGO_NENHUMA_NOTA;
        // Scan from the top so the lowest held index is the one left standing
        for (int i = NUM_NOTAS - 1; i >= 0; i--) begin
            if (notas[i]) cod_prox = 4'(i + 1);
        end
        nova_prox = (cod_prox != CODIGO_NENHUMA_NOTA) && (cod_prox != botoes_encoded);
    end

    // ---------------- edges and arrow lock-out ----------------
    logic [1:0] setas_q;
    logic       enter_q;
    logic       bloqueio;
    logic [1:0] sobe;
    logic       bloqueio_prox;

    assign sobe = setas & ~setas_q;

    // Both arrows down with either one just pressed locks both arrows out;
    // the lock holds until both arrows are released.
    assign bloqueio_prox = ((&setas) && (|sobe)) || (bloqueio && (|setas));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botoes_encoded <= CODIGO_NENHUMA_NOTA;
            nova_nota      <= 1'b0;
            enter_pressed  <= 1'b0;
            enter_q        <= 1'b0;
            setas_q        <= 2'b00;
            bloqueio       <= 1'b0;
        end else begin
            botoes_encoded <= cod_prox;
            nova_nota      <= nova_prox;
            enter_pressed  <= enter_nivel & ~enter_q;
            enter_q        <= enter_nivel;
            setas_q        <= setas;
            bloqueio       <= bloqueio_prox;
        end
    end

    // ---------------- arrow auto-repeat FSMs ----------------
    logic [1:0]      pulsos;
    logic [1:0][1:0] estados;

    for (genvar g = 0; g < 2; g++) begin : g_seta
        estado_seta_t       estado;
        estado_seta_t       estado_prox;
        logic [TIMER_W-1:0] timer;
        logic [TIMER_W-1:0] timer_prox;
        logic               pulso;
        logic               pulso_prox;

        // Timer expiry is taken at 1 so a pulse lands exactly N edges after
        // the load of N.
        always_comb begin
            estado_prox = estado;
            timer_prox  = timer;
            pulso_prox  = 1'b0;
            if (bloqueio_prox || !setas[g]) begin
                estado_prox = OCIOSO;
                timer_prox  = '0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (sobe[g]) begin
                            pulso_prox = 1'b1;
                            if (REPEAT_DELAY != 0) begin
                                estado_prox = ESPERA;
                                timer_prox  = CARGA_ATRASO;
                            end
                        end
                    end
                    ESPERA, REPETE: begin
                        if (timer <= TIMER_W'(1)) begin
                            pulso_prox  = 1'b1;
                            estado_prox = REPETE;
                            timer_prox  = CARGA_PERIODO;
                        end else begin
                            timer_prox = timer - 1'b1;
                        end
                    end
                    default: begin
                        estado_prox = OCIOSO;
                        timer_prox  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                estado <= OCIOSO;
                timer  <= '0;
                pulso  <= 1'b0;
            end else begin
                estado <= estado_prox;
                timer  <= timer_prox;
                pulso  <= pulso_prox;
            end
        end

        assign pulsos[g]  = pulso;
        assign estados[g] = estado;
    end

    assign right_arrow_pressed = pulsos[SETA_DIREITA];
    assign left_arrow_pressed  = pulsos[SETA_ESQUERDA];
    assign estado_direita      = estado_seta_t'(estados[SETA_DIREITA]);
    assign estado_esquerda     = estado_seta_t'(estados[SETA_ESQUERDA]);

endmodule

// File: tb/tb_interface_teclado.sv
module tb_interface_teclado;
    import interface_teclado_pkg::*;

    localparam int NUM_NOTAS = 12;
    localparam int LAT       = 6;   // DEBOUNCE_CYCLES + 2
    localparam int EV_W      = 40;  // {cycle[31:0], enc[3:0], nova, right, left, enter}

    // ---------------- clock / reset ----------------
    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_NOTAS-1:0] teclas_notas = '0;
    logic                 tecla_direita = 1'b0;
    logic                 tecla_esquerda = 1'b0;
    logic                 tecla_enter = 1'b0;
    logic [3:0]           botoes_encoded;
    logic                 nova_nota;
    logic                 right_arrow_pressed;
    logic                 left_arrow_pressed;
    logic                 enter_pressed;
    estado_seta_t         estado_direita;
    estado_seta_t         estado_esquerda;

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    interface_teclado #(
        .NUM_NOTAS       (NUM_NOTAS),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .teclas_notas        (teclas_notas),
        .tecla_direita       (tecla_direita),
        .tecla_esquerda      (tecla_esquerda),
        .tecla_enter         (tecla_enter),
        .botoes_encoded      (botoes_encoded),
        .nova_nota           (nova_nota),
        .right_arrow_pressed (right_arrow_pressed),
        .left_arrow_pressed  (left_arrow_pressed),
        .enter_pressed       (enter_pressed),
        .estado_direita      (estado_direita),
        .estado_esquerda     (estado_esquerda)
    );

    // ---------------- scoreboard ----------------
    logic [EV_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic void push_ev(input int unsigned c, input logic [3:0] e,
                                    input logic n, input logic r, input logic l,
                                    input logic en);
        exp_q.push_back({c, e, n, r, l, en});
    endfunction

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nome, act, expv);
        end
    endtask

    // Monitor: any change of botoes_encoded or any pulse is an output event
    logic [3:0]      prev_enc = 4'd0;
    logic [EV_W-1:0] act_ev;
    logic [EV_W-1:0] exp_ev;

    always @(posedge clock) begin
        #1;
        if (botoes_encoded != prev_enc || nova_nota || right_arrow_pressed ||
            left_arrow_pressed || enter_pressed) begin
            act_ev = {cyc, botoes_encoded, nova_nota, right_arrow_pressed,
                      left_arrow_pressed, enter_pressed};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=%h expected=none", act_ev);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    failures++;
                    $display("FAIL output_event actual=%h expected=%h", act_ev, exp_ev);
                end
            end
        end
        prev_enc = botoes_encoded;
    end

    // ---------------- driver ----------------
    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_zerado(input string tag);
        check({tag, "_enc"},   32'(botoes_encoded), 32'd0);
        check({tag, "_nova"},  32'(nova_nota), 32'd0);
        check({tag, "_right"}, 32'(right_arrow_pressed), 32'd0);
        check({tag, "_left"},  32'(left_arrow_pressed), 32'd0);
        check({tag, "_enter"}, 32'(enter_pressed), 32'd0);
        check({tag, "_est_d"}, 32'(estado_direita), 32'(OCIOSO));
        check({tag, "_est_e"}, 32'(estado_esquerda), 32'(OCIOSO));
    endtask

    initial begin
        #2 reset = 1'b0;
        ciclos(3);
        check_zerado("reset");
        reset = 1'b1;
        ciclos(3);

        // 1: clean press of key 4 -> 5, then release -> 0
        teclas_notas[4] = 1'b1;
        push_ev(cyc + LAT, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        ciclos(10);
        teclas_notas[4] = 1'b0;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ciclos(10);

        // 2: bounce for 12 cycles, then hold
        for (int k = 0; k < 6; k++) begin
            teclas_notas[4] = (k % 2 == 0);
            ciclos(2);
        end
        teclas_notas[4] = 1'b1;
        push_ev(cyc + LAT, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        ciclos(10);
        teclas_notas[4] = 1'b0;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ciclos(10);

        // 3: keys 2 and 7 -> 3; release 2 -> 8; release 7 -> 0
        teclas_notas[2] = 1'b1;
        teclas_notas[7] = 1'b1;
        push_ev(cyc + LAT, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        ciclos(10);
        teclas_notas[2] = 1'b0;
        push_ev(cyc + LAT, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        ciclos(10);
        teclas_notas[7] = 1'b0;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ciclos(10);

        // 4: right held -> press at t0, repeats at +20, +28 ... +60
        tecla_direita = 1'b1;
        push_ev(cyc + LAT,      4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_ev(cyc + LAT + 20, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_ev(cyc + LAT + 28, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_ev(cyc + LAT + 36, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_ev(cyc + LAT + 44, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_ev(cyc + LAT + 52, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_ev(cyc + LAT + 60, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        ciclos(62);   // debounced release lands at t0+62
        tecla_direita = 1'b0;
        ciclos(20);

        // 4b: left pressed while right held -> lock-out until both released
        tecla_direita = 1'b1;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        ciclos(10);
        tecla_esquerda = 1'b1;
        ciclos(20);
        tecla_esquerda = 1'b0;
        ciclos(10);
        tecla_direita = 1'b0;
        ciclos(16);

        // 4c: lock cleared -> left alone pulses normally
        tecla_esquerda = 1'b1;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ciclos(10);
        tecla_esquerda = 1'b0;
        ciclos(12);

        // 5: both arrows and enter together -> only the enter pulse
        tecla_direita  = 1'b1;
        tecla_esquerda = 1'b1;
        tecla_enter    = 1'b1;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        ciclos(40);
        tecla_direita  = 1'b0;
        tecla_esquerda = 1'b0;
        tecla_enter    = 1'b0;
        ciclos(12);

        // 6: reset while note 4 and right held
        teclas_notas[4] = 1'b1;
        tecla_direita   = 1'b1;
        push_ev(cyc + LAT, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        ciclos(10);
        reset = 1'b0;
        push_ev(cyc + 1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_zerado("async_reset");
        ciclos(3);
        reset = 1'b1;
        push_ev(cyc + LAT, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        ciclos(10);
        teclas_notas[4] = 1'b0;
        tecla_direita   = 1'b0;
        push_ev(cyc + LAT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ciclos(30);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
